// File: rtl/guess_solver_if.sv
// Handshake bundle between the guess solver and its external comparator.
// Parameter: W - guess/secret width in bits.
// Signals:
//   i_start        - begin a new search
//   i_over/i_under/i_equal - comparator result for the current guess
//   o_guess        - current guess presented to the comparator
//   o_valid        - comparator result is sampled this cycle
//   o_busy         - search in progress
//   o_done/o_fail  - search finished with the secret found / aborted
//   o_count        - guesses issued in the current or last search
// Modports: master = solver side, slave = comparator/driver side.
interface guess_solver_if #(
    parameter int unsigned W = 8
);
    logic         i_start;
    logic         i_over;
    logic         i_under;
    logic         i_equal;
    logic [W-1:0] o_guess;
    logic         o_valid;
    logic         o_busy;
    logic         o_done;
    logic         o_fail;
    logic [3:0]   o_count;

    modport master (
        input  i_start, i_over, i_under, i_equal,
        output o_guess, o_valid, o_busy, o_done, o_fail, o_count
    );

    modport slave (
        output i_start, i_over, i_under, i_equal,
        input  o_guess, o_valid, o_busy, o_done, o_fail, o_count
    );
endinterface

// File: rtl/guess_solver.sv
// Binary-search solver: narrows [lo, hi] using an external comparator
// until the guess equals the secret or the answers become inconsistent.
// Parameters: W (width, 2..14), MAX_GUESSES (guess limit).
// Ports: clk, reset (async, active-high), bus (guess_solver_if.master).
// Optional feature: define GUESS_SOLVER_LIMIT_EN to abort a search whose
// MAX_GUESSES-th answer is not "equal".
module guess_solver #(
    parameter int unsigned W           = 8,
    parameter int unsigned MAX_GUESSES = 6
) (
    input  logic           clk,
    input  logic           reset,
    guess_solver_if.master bus
);
    localparam int unsigned CW   = 4;
    localparam logic [W-1:0] MAXV = {W{1'b1}};
`ifdef GUESS_SOLVER_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, GUESS, CHECK, DONE, FAIL} state_t;

    state_t        r_state, w_state_nxt;
    logic [W-1:0]  r_lo, r_hi, r_guess;
    logic [W-1:0]  w_lo_nxt, w_hi_nxt, w_guess_nxt;
    logic [CW-1:0] r_count, w_count_nxt;
    logic          r_valid, r_busy, r_done, r_fail;
    logic [W:0]    w_sum;
    logic [W-1:0]  w_mid, w_dec, w_inc;
    logic [2:0]    w_resp;

    // Midpoint with a carry bit so lo+hi cannot wrap.
    assign w_sum  = {1'b0, r_lo} + {1'b0, r_hi};
    assign w_mid  = W'(w_sum >> 1);
    assign w_dec  = r_guess - W'(1);
    assign w_inc  = r_guess + W'(1);
    assign w_resp = {bus.i_over, bus.i_under, bus.i_equal};

    // Next-state and datapath updates.
    always_comb begin
        w_state_nxt = r_state;
        w_lo_nxt    = r_lo;
        w_hi_nxt    = r_hi;
        w_guess_nxt = r_guess;
        w_count_nxt = r_count;
        unique case (r_state)
            IDLE, DONE, FAIL: begin
                if (bus.i_start) begin
                    w_state_nxt = GUESS;
                    w_lo_nxt    = '0;
                    w_hi_nxt    = MAXV;
                    w_count_nxt = '0;
                end
            end
            GUESS: begin
                w_guess_nxt = w_mid;
                w_count_nxt = (r_count == {CW{1'b1}}) ? r_count : r_count + CW'(1);
                w_state_nxt = CHECK;
            end
            CHECK: begin
                case (w_resp)
                    3'b001: w_state_nxt = DONE;
                    3'b100: begin
                        // Guess too high: shrink hi, abort if range empties.
                        if (r_guess == '0) begin
                            w_state_nxt = FAIL;
                        end else begin
                            w_hi_nxt    = w_dec;
                            w_state_nxt = (r_lo > w_dec) ? FAIL : GUESS;
                        end
                    end
                    3'b010: begin
                        // Guess too low: raise lo, abort if range empties.
                        if (r_guess == MAXV) begin
                            w_state_nxt = FAIL;
                        end else begin
                            w_lo_nxt    = w_inc;
                            w_state_nxt = (w_inc > r_hi) ? FAIL : GUESS;
                        end
                    end
                    default: w_state_nxt = FAIL;
                endcase
                if (LIMIT_EN && (w_resp != 3'b001) && (r_count == CW'(MAX_GUESSES)))
                    w_state_nxt = FAIL;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, datapath and registered status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_lo    <= '0;
            r_hi    <= MAXV;
            r_guess <= '0;
            r_count <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_fail  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_lo    <= w_lo_nxt;
            r_hi    <= w_hi_nxt;
            r_guess <= w_guess_nxt;
            r_count <= w_count_nxt;
            r_valid <= (w_state_nxt == CHECK);
            r_busy  <= (w_state_nxt == GUESS) || (w_state_nxt == CHECK);
            r_done  <= (w_state_nxt == DONE);
            r_fail  <= (w_state_nxt == FAIL);
        end
    end

    assign bus.o_guess = r_guess;
    assign bus.o_valid = r_valid;
    assign bus.o_busy  = r_busy;
    assign bus.o_done  = r_done;
    assign bus.o_fail  = r_fail;
    assign bus.o_count = r_count;
endmodule

// File: tb/tb_guess_solver.sv
// Self-checking bench for guess_solver: hand-derived vector table, directed
// guess sequences, mid-search reset, and randomized searches against a
// behavioural binary-search model. Honours GUESS_SOLVER_LIMIT_EN.
module tb_guess_solver;
    localparam int unsigned W    = 8;
    localparam int unsigned MAXG = 6;
    localparam int MAXV = (1 << W) - 1;
`ifdef GUESS_SOLVER_LIMIT_EN
    localparam bit LIM = 1'b1;
`else
    localparam bit LIM = 1'b0;
`endif
    localparam int R_DONE = 1;
    localparam int R_FAIL = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    guess_solver_if #(.W(W)) bus ();
    guess_solver #(.W(W), .MAX_GUESSES(MAXG)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_cmp = 0;
    int n_err = 0;
    int exp_q[$];
    int got_q[$];

    typedef struct {
        int secret; int k; int code;
        int exp_result; int exp_count; int exp_last;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Comparator answer {over,under,equal}; guess index k gets forced code.
    function automatic int respond(input int g, input int secret, input int idx,
                                   input int k, input int code);
        if (idx == k) return code;
        if (g > secret) return 4;
        if (g < secret) return 2;
        return 1;
    endfunction

    // Plain binary search following the same answers the bench gives.
    task automatic model(input int secret, input int k, input int code,
                         output int result, output int count);
        int lo, hi, g, r;
        lo = 0; hi = MAXV; count = 0; result = R_FAIL;
        exp_q.delete();
        for (int idx = 0; idx < 64; idx++) begin
            g = (lo + hi) / 2;
            count = (count < 15) ? count + 1 : 15;
            exp_q.push_back(g);
            r = respond(g, secret, idx, k, code);
            if (LIM && r != 1 && count == MAXG) begin result = R_FAIL; break; end
            if (r == 1) begin result = R_DONE; break; end
            else if (r == 4) begin
                if (g == 0) begin result = R_FAIL; break; end
                hi = g - 1;
            end else if (r == 2) begin
                if (g == MAXV) begin result = R_FAIL; break; end
                lo = g + 1;
            end else begin result = R_FAIL; break; end
            if (lo > hi) begin result = R_FAIL; break; end
        end
    endtask

    // Pulse start, answer each CHECK, stop on done/fail or budget expiry.
    task automatic run_search(input int secret, input int k, input int code,
                              input int glitch_at, output int result,
                              output int count, output int last, output int cycles);
        int idx, r;
        got_q.delete();
        idx = 0; result = 0;
        bus.i_start = 1'b1;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        cycles = 1;
        while (cycles < 200) begin
            {bus.i_over, bus.i_under, bus.i_equal} = 3'b000;
            if (bus.o_done) begin result = R_DONE; break; end
            if (bus.o_fail) begin result = R_FAIL; break; end
            if (bus.o_valid) begin
                got_q.push_back(int'(bus.o_guess));
                r = respond(int'(bus.o_guess), secret, idx, k, code);
                idx++;
                {bus.i_over, bus.i_under, bus.i_equal} = 3'(r);
            end
            bus.i_start = (cycles == glitch_at) && bus.o_busy;
            @(posedge clk); #1;
            cycles++;
        end
        bus.i_start = 1'b0;
        {bus.i_over, bus.i_under, bus.i_equal} = 3'b000;
        if (result == 0) $display("FAIL timeout: no done/fail within %0d cycles", cycles);
        count = int'(bus.o_count);
        last  = int'(bus.o_guess);
    endtask

    // DONE/FAIL must hold their outputs while start stays low.
    task automatic check_hold(input int result, input int last);
        repeat (2) @(posedge clk);
        #1;
        check("hold_done", int'(bus.o_done), (result == R_DONE) ? 1 : 0);
        check("hold_fail", int'(bus.o_fail), (result == R_FAIL) ? 1 : 0);
        check("hold_guess", int'(bus.o_guess), last);
        check("hold_busy", int'(bus.o_busy), 0);
    endtask

    task automatic add(input int s, input int k, input int c,
                       input int r, input int n, input int l);
        vec_t v;
        v.secret = s; v.k = k; v.code = c;
        v.exp_result = r; v.exp_count = n; v.exp_last = l;
        tbl.push_back(v);
    endtask

    initial begin
        int res, cnt, last, cyc, eres, ecnt, nv;
        int seq0[8];
        int seq255[9];
        seq0   = '{127, 63, 31, 15, 7, 3, 1, 0};
        seq255 = '{127, 191, 223, 239, 247, 251, 253, 254, 255};

        reset = 1'b1;
        bus.i_start = 1'b0;
        {bus.i_over, bus.i_under, bus.i_equal} = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        check("rst_guess", int'(bus.o_guess), 0);
        check("rst_valid", int'(bus.o_valid), 0);
        check("rst_busy", int'(bus.o_busy), 0);
        check("rst_done", int'(bus.o_done), 0);
        check("rst_fail", int'(bus.o_fail), 0);
        check("rst_count", int'(bus.o_count), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        add(127, -1, 0, R_DONE, 1, 127);
        add(127, 0, 6, R_FAIL, 1, 127);
        add(127, 0, 0, R_FAIL, 1, 127);
        add(127, 0, 7, R_FAIL, 1, 127);
        if (LIM) begin
            add(0,   -1, 0, R_FAIL, 6, 3);
            add(255, -1, 0, R_FAIL, 6, 251);
            add(128, -1, 0, R_FAIL, 6, 131);
            add(127, 0,  4, R_FAIL, 6, 123);
            add(0,   7,  4, R_FAIL, 6, 3);
            add(255, 8,  2, R_FAIL, 6, 251);
            add(200, -1, 0, R_FAIL, 6, 203);
        end else begin
            add(0,   -1, 0, R_DONE, 8, 0);
            add(255, -1, 0, R_DONE, 9, 255);
            add(128, -1, 0, R_DONE, 8, 128);
            add(127, 0,  4, R_FAIL, 8, 126);
            add(0,   7,  4, R_FAIL, 8, 0);
            add(255, 8,  2, R_FAIL, 9, 255);
            add(200, -1, 0, R_DONE, 8, 200);
        end

        for (int i = 0; i < tbl.size(); i++) begin
            run_search(tbl[i].secret, tbl[i].k, tbl[i].code, 0, res, cnt, last, cyc);
            check($sformatf("tbl%0d_result", i), res, tbl[i].exp_result);
            check($sformatf("tbl%0d_count", i), cnt, tbl[i].exp_count);
            check($sformatf("tbl%0d_guess", i), last, tbl[i].exp_last);
            check($sformatf("tbl%0d_cycles", i), cyc, 2 * tbl[i].exp_count + 1);
            check($sformatf("tbl%0d_busy", i), int'(bus.o_busy), 0);
            if (i == 0) check_hold(res, last);
        end

        if (!LIM) begin
            run_search(0, -1, 0, 0, res, cnt, last, cyc);
            check("seq0_len", got_q.size(), 8);
            for (int j = 0; j < 8 && j < got_q.size(); j++)
                check($sformatf("seq0_g%0d", j), got_q[j], seq0[j]);
            run_search(255, -1, 0, 0, res, cnt, last, cyc);
            check("seq255_len", got_q.size(), 9);
            for (int j = 0; j < 9 && j < got_q.size(); j++)
                check($sformatf("seq255_g%0d", j), got_q[j], seq255[j]);
            check("seq255_cycles", cyc, 19);
        end

        // Reset while the 3rd guess is being checked, then restart.
        bus.i_start = 1'b1;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        nv = 0;
        for (int c = 0; c < 40 && nv < 3; c++) begin
            {bus.i_over, bus.i_under, bus.i_equal} = 3'b000;
            if (bus.o_valid) begin
                nv++;
                if (nv < 3)
                    {bus.i_over, bus.i_under, bus.i_equal} =
                        3'(respond(int'(bus.o_guess), 200, -2, -1, 0));
            end
            if (nv < 3) begin @(posedge clk); #1; end
        end
        check("rst_mid_reached", nv, 3);
        #2 reset = 1'b1;
        #1;
        check("midrst_guess", int'(bus.o_guess), 0);
        check("midrst_valid", int'(bus.o_valid), 0);
        check("midrst_busy", int'(bus.o_busy), 0);
        check("midrst_done", int'(bus.o_done), 0);
        check("midrst_fail", int'(bus.o_fail), 0);
        check("midrst_count", int'(bus.o_count), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        model(200, -1, 0, eres, ecnt);
        run_search(200, -1, 0, 0, res, cnt, last, cyc);
        check("restart_result", res, eres);
        check("restart_guess", last, exp_q[exp_q.size()-1]);
        if (!LIM) check("restart_is_200", last, 200);

        // Randomized searches, some with a corrupted answer or a stray start.
        for (int i = 0; i < 40; i++) begin
            int s, k, code, g;
            s = int'($urandom_range(0, MAXV));
            k = -1; code = 0;
            if ($urandom_range(0, 3) == 0) begin
                k    = int'($urandom_range(0, 8));
                code = int'($urandom_range(0, 7));
            end
            g = int'($urandom_range(0, 12));
            model(s, k, code, eres, ecnt);
            run_search(s, k, code, g, res, cnt, last, cyc);
            check($sformatf("rnd%0d_s%0d_result", i, s), res, eres);
            check($sformatf("rnd%0d_s%0d_count", i, s), cnt, ecnt);
            check($sformatf("rnd%0d_s%0d_cycles", i, s), cyc, 2 * ecnt + 1);
            check($sformatf("rnd%0d_s%0d_len", i, s), got_q.size(), exp_q.size());
            if (got_q.size() == exp_q.size()) begin
                for (int j = 0; j < exp_q.size(); j++)
                    check($sformatf("rnd%0d_g%0d", i, j), got_q[j], exp_q[j]);
                check($sformatf("rnd%0d_last", i), last, exp_q[exp_q.size()-1]);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/guess_solver.md
GUESS_SOLVER -- requirements
Module: guess_solver

Interface
REQ-001 The module SHALL have parameter W, default 8, giving the guess/secret width in bits (legal 2..14).
REQ-002 The module SHALL have parameter MAX_GUESSES, default 6, giving the guess limit (used only when GUESS_SOLVER_LIMIT_EN is defined).
REQ-003 The module SHALL have port clk  input  1  rising-edge clock.
REQ-004 The module SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The module SHALL have port i_start  input  1  begin a new search (single-cycle pulse or level).
REQ-006 The module SHALL have port i_over  input  1  comparator result: current guess > secret.
REQ-007 The module SHALL have port i_under  input  1  comparator result: current guess < secret.
REQ-008 The module SHALL have port i_equal  input  1  comparator result: current guess == secret.
REQ-009 The module SHALL have port o_guess  output  W  current guess, driven to the comparator.
REQ-010 The module SHALL have port o_valid  output  1  o_guess is stable and the comparator result is being sampled this cycle.
REQ-011 The module SHALL have port o_busy  output  1  a search is in progress.
REQ-012 The module SHALL have port o_done  output  1  the secret has been found and o_guess holds it.
REQ-013 The module SHALL have port o_fail  output  1  the search was aborted.
REQ-014 The module SHALL have port o_count  output  4  number of guesses issued in the current or last search.

Function
REQ-015 The FSM SHALL have exactly these states: IDLE, GUESS, CHECK, DONE and FAIL.
REQ-016 An i_start sampled in IDLE, DONE or FAIL SHALL cause these updates on the next edge: state to GUESS, lo to 0, hi to 2^W-1, o_count to 0, and o_done and o_fail to 0.
REQ-017 i_start SHALL be ignored in GUESS and CHECK.
REQ-018 In GUESS, the next edge SHALL register o_guess = (lo+hi)>>1, computed with a W+1-bit sum, SHALL increment o_count (saturating at 15), and SHALL move to CHECK.
REQ-019 In CHECK, o_valid SHALL be 1, o_guess SHALL be unchanged, and i_over, i_under and i_equal SHALL be sampled on the edge that leaves CHECK.
REQ-020 CHECK with exactly i_equal=1 SHALL go to DONE, leaving o_guess and o_count unchanged.
REQ-021 CHECK with exactly i_over=1 SHALL set hi = o_guess-1 and go to GUESS; if o_guess==0, it SHALL instead go to FAIL.
REQ-022 CHECK with exactly i_under=1 SHALL set lo = o_guess+1 and go to GUESS; if o_guess==2^W-1, it SHALL instead go to FAIL.
REQ-023 CHECK with zero or more than one of i_over, i_under and i_equal asserted SHALL go to FAIL.
REQ-024 A CHECK update that leaves lo > hi SHALL go to FAIL instead of GUESS.
REQ-025 Each guess SHALL take exactly 2 cycles, and o_done SHALL rise 2N+1 cycles after the i_start edge for a search of N guesses.
REQ-026 o_busy SHALL be 1 exactly in GUESS and CHECK.
REQ-027 o_done SHALL be 1 exactly in DONE, and o_fail SHALL be 1 exactly in FAIL.
REQ-028 DONE and FAIL SHALL hold their outputs until i_start or reset.

Reset
REQ-029 Reset SHALL force IDLE, with o_guess=0, o_valid=0, o_busy=0, o_done=0, o_fail=0, o_count=0, lo=0 and hi=2^W-1.
REQ-030 Reset asserted mid-search SHALL abort the search immediately (asynchronously), and the first i_start after reset release SHALL begin a fresh search.

Configuration
REQ-031 With macro GUESS_SOLVER_LIMIT_EN defined, a CHECK whose sampled result is not i_equal while o_count==MAX_GUESSES SHALL go to FAIL.
REQ-032 With GUESS_SOLVER_LIMIT_EN undefined, there SHALL be no guess limit, and the search SHALL end only on equal or on the REQ-021 to REQ-024 failure conditions.

Verification
REQ-033 The bench SHALL cover: W=8, secret 127, start pulse at cycle 0 -> o_guess=127, o_done high at cycle 3, o_count=1, o_fail=0.
REQ-034 The bench SHALL cover: secret 0, GUESS_SOLVER_LIMIT_EN undefined -> guess sequence 127,63,31,15,7,3,1,0 and done with o_count=8.
REQ-035 The bench SHALL cover: secret 255 -> guess sequence 127,191,223,239,247,251,253,254,255, o_count=9, o_done high 19 cycles after start.
REQ-036 The bench SHALL cover: i_over=i_under=1 in the first CHECK -> FAIL, o_fail=1, o_count=1, o_busy=0.
REQ-037 The bench SHALL cover: reset asserted during the 3rd CHECK -> all outputs 0, IDLE; a restart with secret 200 -> done with o_guess=200.
REQ-038 The bench SHALL cover: GUESS_SOLVER_LIMIT_EN defined, MAX_GUESSES=6, secret 0 -> FAIL after guess 3 is answered, with o_count=6 and o_done=0.
